// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared types and helpers for the digital clock timekeeping block.
//   mode_t        : set-mode encodings driven on MODE (RUN / SET_HR / SET_MIN)
//   clock_time_t  : packed h:m:s BCD time plus the 12-hour PM flag
//   *_MAX         : BCD wrap points, written as two-digit BCD bytes
//   bcd_sexa_inc  : +1 on a 00-59 BCD pair
//   hour_inc      : +1 on the hours (24h or 12h wrap, PM toggle at 11 -> 12)
//   second_advance: one 1 Hz step with the full s -> m -> h carry cascade
// ---------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'b00,
    MODE_SET_HR  = 2'b01,
    MODE_SET_MIN = 2'b10
  } mode_t;

  localparam logic [7:0] SEC_MAX      = 8'h59;
  localparam logic [7:0] MIN_MAX      = 8'h59;
  localparam logic [7:0] HR24_MAX     = 8'h23;
  localparam logic [7:0] HR12_MAX     = 8'h12;
  // Hour value at which the 12-hour clock crosses into the other half-day.
  localparam logic [7:0] HR12_PM_EDGE = 8'h11;

  typedef struct packed {
    logic       pm;
    logic [1:0] hr_tens;
    logic [3:0] hr_ones;
    logic [2:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
  } clock_time_t;

  function automatic logic bcd_sexa_at_max(input logic [2:0] tens,
                                           input logic [3:0] ones,
                                           input logic [7:0] max_val);
    return ({1'b0, tens, ones} == max_val);
  endfunction

  // Digit-wise increment keeps each digit in its legal BCD range without
  // ever going through a binary value.
  function automatic logic [6:0] bcd_sexa_inc(input logic [2:0] tens,
                                              input logic [3:0] ones,
                                              input logic [7:0] max_val);
    if (bcd_sexa_at_max(tens, ones, max_val)) return 7'h00;
    else if (ones == 4'd9)                     return {tens + 3'd1, 4'd0};
    else                                       return {tens, ones + 4'd1};
  endfunction

  function automatic clock_time_t hour_inc(input clock_time_t t,
                                           input logic        hour_24);
    clock_time_t r;
    r = t;
    if (hour_24) begin
      if ({2'b00, t.hr_tens, t.hr_ones} == HR24_MAX) begin
        {r.hr_tens, r.hr_ones} = 6'h00;
      end else if (t.hr_ones == 4'd9) begin
        r.hr_tens = t.hr_tens + 2'd1;
        r.hr_ones = 4'd0;
      end else begin
        r.hr_ones = t.hr_ones + 4'd1;
      end
    end else begin
      // 12 -> 01 keeps the half-day; 11 -> 12 is where AM/PM flips.
      if ({2'b00, t.hr_tens, t.hr_ones} == HR12_MAX) begin
        {r.hr_tens, r.hr_ones} = 6'h01;
      end else if ({2'b00, t.hr_tens, t.hr_ones} == HR12_PM_EDGE) begin
        {r.hr_tens, r.hr_ones} = 6'h12;
        r.pm = ~t.pm;
      end else if (t.hr_ones == 4'd9) begin
        r.hr_tens = t.hr_tens + 2'd1;
        r.hr_ones = 4'd0;
      end else begin
        r.hr_ones = t.hr_ones + 4'd1;
      end
    end
    return r;
  endfunction

  // All carries resolve combinationally so every digit lands in one cycle.
  function automatic clock_time_t second_advance(input clock_time_t t,
                                                 input logic        hour_24);
    clock_time_t r;
    r = t;
    {r.sec_tens, r.sec_ones} = bcd_sexa_inc(t.sec_tens, t.sec_ones, SEC_MAX);
    if (bcd_sexa_at_max(t.sec_tens, t.sec_ones, SEC_MAX)) begin
      {r.min_tens, r.min_ones} = bcd_sexa_inc(t.min_tens, t.min_ones, MIN_MAX);
      if (bcd_sexa_at_max(t.min_tens, t.min_ones, MIN_MAX)) begin
        r = hour_inc(r, hour_24);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_conditioner.sv
// ---------------------------------------------------------------------------
// key_conditioner
// Turns a raw, bouncing, asynchronous active-low pushbutton into a single
// one-cycle press pulse.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset (key treated as released)
//   key_n  in  raw pushbutton, active-low, asynchronous to clk
//   press  out one-cycle pulse on an accepted released -> pressed change
// A new level is accepted only after it has been seen on the synchronized
// input for DEBOUNCE_CYCLES consecutive cycles; any return to the accepted
// level restarts the count. Holding the key yields exactly one pulse.
// ---------------------------------------------------------------------------
module key_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync_meta;
  logic             sync_level;
  logic             stable_level;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  // The count reaching CNT_LAST on a differing sample is the
  // DEBOUNCE_CYCLES-th consecutive sample of the new level.
  assign accept = (sync_level != stable_level) && (cnt == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values; blocking here would collapse the
  // two-flop synchronizer into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta    <= 1'b1;
      sync_level   <= 1'b1;
      stable_level <= 1'b1;
      cnt          <= '0;
      press        <= 1'b0;
    end else begin
      sync_meta  <= key_n;
      sync_level <= sync_meta;
      press      <= accept && !sync_level;
      if (sync_level == stable_level) begin
        cnt <= '0;
      end else if (accept) begin
        stable_level <= sync_level;
        cnt          <= '0;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/clock_set_controller.sv
// ---------------------------------------------------------------------------
// clock_set_controller
// Timekeeping and two-button set-mode controller for the digital clock,
// fed by the 50 MHz -> 1 Hz divider chain.
//   CLK        in   system clock (50 MHz)
//   CLEAR_N    in   asynchronous active-low reset
//   TICK_1HZ   in   one-CLK pulse per second
//   KEY_MODE_N in   raw MODE pushbutton, active-low
//   KEY_INC_N  in   raw INC pushbutton, active-low
//   HR_TENS/HR_ONES, MIN_TENS/MIN_ONES, SEC_TENS/SEC_ONES  out  BCD digits
//   PM         out  PM flag (12-hour build only, otherwise 0)
//   MODE       out  00 RUN, 01 SET_HR, 10 SET_MIN
//   BLINK      out  blank the digits under edit on this display phase
//   DIV_CLEAR  out  one-CLK pulse restarting the divider on leaving set mode
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module clock_set_controller
  import clock_pkg::*;
#(
  parameter int HOUR_24         = 1,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLK,
  input  logic       CLEAR_N,
  input  logic       TICK_1HZ,
  input  logic       KEY_MODE_N,
  input  logic       KEY_INC_N,
  output logic [1:0] HR_TENS,
  output logic [3:0] HR_ONES,
  output logic [2:0] MIN_TENS,
  output logic [3:0] MIN_ONES,
  output logic [2:0] SEC_TENS,
  output logic [3:0] SEC_ONES,
  output logic       PM,
  output logic [1:0] MODE,
  output logic       BLINK,
  output logic       DIV_CLEAR
);

  localparam logic IS_24H = (HOUR_24 != 0);
  // 00:00:00 for the 24-hour build, 12:00:00 AM for the 12-hour build.
  localparam clock_time_t RESET_TIME =
    clock_time_t'({1'b0, (IS_24H ? 6'h00 : 6'h12), 14'h0000});

  logic        mode_press;
  logic        inc_press;

  mode_t       mode_q,      mode_nxt;
  clock_time_t time_q,      time_nxt;
  logic        blink_q,     blink_nxt;
  logic        div_clear_q, div_clear_nxt;

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
    .clk   (CLK),
    .rst_n (CLEAR_N),
    .key_n (KEY_MODE_N),
    .press (mode_press)
  );

  key_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
    .clk   (CLK),
    .rst_n (CLEAR_N),
    .key_n (KEY_INC_N),
    .press (inc_press)
  );

  // NOTE: every signal written here gets a default before the case, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    mode_nxt      = mode_q;
    time_nxt      = time_q;
    blink_nxt     = blink_q;
    div_clear_nxt = 1'b0;

    case (mode_q)
      MODE_RUN: begin
        blink_nxt = 1'b0;
        // A tick coinciding with the MODE press still counts.
        if (TICK_1HZ) time_nxt = second_advance(time_q, IS_24H);
        if (mode_press) mode_nxt = MODE_SET_HR;
      end

      MODE_SET_HR: begin
        // MODE has priority: a simultaneous INC is dropped.
        if (mode_press) begin
          mode_nxt  = MODE_SET_MIN;
          blink_nxt = 1'b0;
        end else if (inc_press) begin
          time_nxt  = hour_inc(time_q, IS_24H);
          blink_nxt = 1'b0;
        end else if (TICK_1HZ) begin
          blink_nxt = ~blink_q;
        end
      end

      MODE_SET_MIN: begin
        if (mode_press) begin
          // Leaving set mode restarts the second from zero, both here and
          // in the divider chain.
          mode_nxt          = MODE_RUN;
          blink_nxt         = 1'b0;
          time_nxt.sec_tens = 3'd0;
          time_nxt.sec_ones = 4'd0;
          div_clear_nxt     = 1'b1;
        end else if (inc_press) begin
          {time_nxt.min_tens, time_nxt.min_ones} =
            bcd_sexa_inc(time_q.min_tens, time_q.min_ones, MIN_MAX);
          blink_nxt = 1'b0;
        end else if (TICK_1HZ) begin
          blink_nxt = ~blink_q;
        end
      end

      default: begin
        // Illegal encoding: back to RUN, time held, no divider clear.
        mode_nxt  = MODE_RUN;
        blink_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge CLEAR_N) begin
    if (!CLEAR_N) begin
      mode_q      <= MODE_RUN;
      time_q      <= RESET_TIME;
      blink_q     <= 1'b0;
      div_clear_q <= 1'b0;
    end else begin
      mode_q      <= mode_nxt;
      time_q      <= time_nxt;
      blink_q     <= blink_nxt;
      div_clear_q <= div_clear_nxt;
    end
  end

  assign HR_TENS   = time_q.hr_tens;
  assign HR_ONES   = time_q.hr_ones;
  assign MIN_TENS  = time_q.min_tens;
  assign MIN_ONES  = time_q.min_ones;
  assign SEC_TENS  = time_q.sec_tens;
  assign SEC_ONES  = time_q.sec_ones;
  assign PM        = IS_24H ? 1'b0 : time_q.pm;
  assign MODE      = mode_q;
  assign BLINK     = blink_q;
  assign DIV_CLEAR = div_clear_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// ---------------------------------------------------------------------------
// tb_clock_set_controller
// Directed bench for clock_set_controller. Instance 0 is the 24-hour build,
// instance 1 the 12-hour build; both use DEBOUNCE_CYCLES = 4. Times are
// compared as a 24-bit BCD word hh_mm_ss (e.g. 24'h235959).
// ---------------------------------------------------------------------------
module tb_clock_set_controller;

  localparam int DEB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear_n    [2];
  logic       tick       [2];
  logic       key_mode_n [2];
  logic       key_inc_n  [2];
  logic [1:0] hr_tens    [2];
  logic [3:0] hr_ones    [2];
  logic [2:0] min_tens   [2];
  logic [3:0] min_ones   [2];
  logic [2:0] sec_tens   [2];
  logic [3:0] sec_ones   [2];
  logic       pm         [2];
  logic [1:0] mode       [2];
  logic       blink      [2];
  logic       div_clear  [2];

  int vectors     = 0;
  int miscompares = 0;
  int dc_cnt [2]  = '{0, 0};

  clock_set_controller #(.HOUR_24(1), .DEBOUNCE_CYCLES(DEB)) dut_24 (
    .CLK(clk), .CLEAR_N(clear_n[0]), .TICK_1HZ(tick[0]),
    .KEY_MODE_N(key_mode_n[0]), .KEY_INC_N(key_inc_n[0]),
    .HR_TENS(hr_tens[0]), .HR_ONES(hr_ones[0]),
    .MIN_TENS(min_tens[0]), .MIN_ONES(min_ones[0]),
    .SEC_TENS(sec_tens[0]), .SEC_ONES(sec_ones[0]),
    .PM(pm[0]), .MODE(mode[0]), .BLINK(blink[0]), .DIV_CLEAR(div_clear[0])
  );

  clock_set_controller #(.HOUR_24(0), .DEBOUNCE_CYCLES(DEB)) dut_12 (
    .CLK(clk), .CLEAR_N(clear_n[1]), .TICK_1HZ(tick[1]),
    .KEY_MODE_N(key_mode_n[1]), .KEY_INC_N(key_inc_n[1]),
    .HR_TENS(hr_tens[1]), .HR_ONES(hr_ones[1]),
    .MIN_TENS(min_tens[1]), .MIN_ONES(min_ones[1]),
    .SEC_TENS(sec_tens[1]), .SEC_ONES(sec_ones[1]),
    .PM(pm[1]), .MODE(mode[1]), .BLINK(blink[1]), .DIV_CLEAR(div_clear[1])
  );

  // Count DIV_CLEAR cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (div_clear[0] === 1'b1) dc_cnt[0]++;
    if (div_clear[1] === 1'b1) dc_cnt[1]++;
  end

  function automatic logic [23:0] hms(input int d);
    return {2'b00, hr_tens[d], hr_ones[d], 1'b0, min_tens[d], min_ones[d],
            1'b0, sec_tens[d], sec_ones[d]};
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One clean press: held 10 cycles (accepted after sync + 4), released 10.
  task automatic press(input int d, input bit inc);
    if (inc) key_inc_n[d] = 1'b0; else key_mode_n[d] = 1'b0;
    step(10);
    if (inc) key_inc_n[d] = 1'b1; else key_mode_n[d] = 1'b1;
    step(10);
  endtask

  task automatic press_n(input int d, input bit inc, input int n);
    repeat (n) press(d, inc);
  endtask

  task automatic set_time(input int d, input int h_n, input int m_n);
    press(d, 1'b0);
    press_n(d, 1'b1, h_n);
    press(d, 1'b0);
    press_n(d, 1'b1, m_n);
    press(d, 1'b0);
  endtask

  task automatic ticks(input int d, input int n);
    repeat (n) begin
      tick[d] = 1'b1;
      step(1);
      tick[d] = 1'b0;
      step(1);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      clear_n[d] = 1'b0; tick[d] = 1'b0;
      key_mode_n[d] = 1'b1; key_inc_n[d] = 1'b1;
    end
    step(3);
    vectors++;
    if (hms(0) !== 24'h000000) begin
      miscompares++; $display("FAIL reset_time_24h: got %h want %h", hms(0), 24'h000000);
    end
    vectors++;
    if (mode[0] !== 2'b00 || blink[0] !== 1'b0 || div_clear[0] !== 1'b0 || pm[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl_24h: got mode=%b blink=%b divclr=%b pm=%b want 00 0 0 0",
               mode[0], blink[0], div_clear[0], pm[0]);
    end
    vectors++;
    if (hms(1) !== 24'h120000 || pm[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_time_12h: got %h pm=%b want 120000 pm=0", hms(1), pm[1]);
    end
    vectors++;
    if (mode[1] !== 2'b00 || blink[1] !== 1'b0 || div_clear[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl_12h: got mode=%b blink=%b divclr=%b want 00 0 0",
               mode[1], blink[1], div_clear[1]);
    end
    clear_n[0] = 1'b1;
    clear_n[1] = 1'b1;
    step(2);
  endtask

  task automatic test_run_tick();
    tick[0] = 1'b1;
    step(1);
    tick[0] = 1'b0;
    vectors++;
    if (hms(0) !== 24'h000001) begin
      miscompares++; $display("FAIL run_tick: got %h want %h", hms(0), 24'h000001);
    end
    step(3);
    vectors++;
    if (hms(0) !== 24'h000001) begin
      miscompares++; $display("FAIL run_hold_no_tick: got %h want %h", hms(0), 24'h000001);
    end
  endtask

  task automatic test_set_sequence();
    int dc0;
    dc0 = dc_cnt[0];
    press(0, 1'b0);
    vectors++;
    if (mode[0] !== 2'b01 || hms(0) !== 24'h000001) begin
      miscompares++;
      $display("FAIL set_enter_hr: got mode=%b time=%h want 01 000001", mode[0], hms(0));
    end
    ticks(0, 1);
    vectors++;
    if (hms(0) !== 24'h000001 || blink[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL set_hr_tick: got time=%h blink=%b want 000001 1", hms(0), blink[0]);
    end
    press(0, 1'b1);
    vectors++;
    if (hms(0) !== 24'h010001 || blink[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL set_first_inc: got time=%h blink=%b want 010001 0", hms(0), blink[0]);
    end
    press_n(0, 1'b1, 4);
    vectors++;
    if (hms(0) !== 24'h050001) begin
      miscompares++; $display("FAIL set_hr_five: got %h want %h", hms(0), 24'h050001);
    end
    press(0, 1'b0);
    vectors++;
    if (mode[0] !== 2'b10) begin
      miscompares++; $display("FAIL set_enter_min: got mode=%b want 10", mode[0]);
    end
    press_n(0, 1'b1, 3);
    ticks(0, 2);
    vectors++;
    if (hms(0) !== 24'h050301) begin
      miscompares++; $display("FAIL set_min_three: got %h want %h", hms(0), 24'h050301);
    end
    press(0, 1'b0);
    vectors++;
    if (mode[0] !== 2'b00 || hms(0) !== 24'h050300 || blink[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL set_exit: got mode=%b time=%h blink=%b want 00 050300 0",
               mode[0], hms(0), blink[0]);
    end
    vectors++;
    if (dc_cnt[0] - dc0 !== 1) begin
      miscompares++; $display("FAIL set_div_clear_count: got %0d want 1", dc_cnt[0] - dc0);
    end
  endtask

  task automatic test_rollover_24();
    set_time(0, 18, 56);
    vectors++;
    if (hms(0) !== 24'h235900) begin
      miscompares++; $display("FAIL preload_2359: got %h want %h", hms(0), 24'h235900);
    end
    ticks(0, 59);
    vectors++;
    if (hms(0) !== 24'h235959) begin
      miscompares++; $display("FAIL preload_235959: got %h want %h", hms(0), 24'h235959);
    end
    tick[0] = 1'b1;
    step(1);
    tick[0] = 1'b0;
    vectors++;
    if (hms(0) !== 24'h000000) begin
      miscompares++; $display("FAIL rollover_24h: got %h want %h", hms(0), 24'h000000);
    end
  endtask

  task automatic test_debounce();
    press(0, 1'b0);
    ticks(0, 1);
    vectors++;
    if (mode[0] !== 2'b01 || blink[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL deb_setup: got mode=%b blink=%b want 01 1", mode[0], blink[0]);
    end
    repeat (3) begin
      key_inc_n[0] = 1'b0; step(3);
      key_inc_n[0] = 1'b1; step(2);
    end
    key_inc_n[0] = 1'b0;
    step(10);
    vectors++;
    if (hms(0) !== 24'h010000 || blink[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL deb_bounce_one_inc: got time=%h blink=%b want 010000 0", hms(0), blink[0]);
    end
    key_inc_n[0] = 1'b1;
    step(10);
    vectors++;
    if (hms(0) !== 24'h010000) begin
      miscompares++; $display("FAIL deb_release_no_inc: got %h want %h", hms(0), 24'h010000);
    end
    press(0, 1'b1);
    vectors++;
    if (hms(0) !== 24'h020000) begin
      miscompares++; $display("FAIL deb_second_press: got %h want %h", hms(0), 24'h020000);
    end
  endtask

  task automatic test_mode_inc_same_cycle();
    key_mode_n[0] = 1'b0;
    key_inc_n[0]  = 1'b0;
    step(10);
    key_mode_n[0] = 1'b1;
    key_inc_n[0]  = 1'b1;
    step(10);
    vectors++;
    if (mode[0] !== 2'b10 || hms(0) !== 24'h020000) begin
      miscompares++;
      $display("FAIL mode_inc_same: got mode=%b time=%h want 10 020000", mode[0], hms(0));
    end
  endtask

  task automatic test_reset_mid_edit();
    int dc0;
    ticks(0, 1);
    vectors++;
    if (blink[0] !== 1'b1) begin
      miscompares++; $display("FAIL mid_edit_blink: got %b want 1", blink[0]);
    end
    dc0 = dc_cnt[0];
    #2;
    clear_n[0] = 1'b0;
    #1;
    vectors++;
    if (mode[0] !== 2'b00 || hms(0) !== 24'h000000 || blink[0] !== 1'b0 || div_clear[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_mid_edit: got mode=%b time=%h blink=%b divclr=%b want 00 000000 0 0",
               mode[0], hms(0), blink[0], div_clear[0]);
    end
    step(2);
    clear_n[0] = 1'b1;
    step(2);
    vectors++;
    if (dc_cnt[0] - dc0 !== 0) begin
      miscompares++; $display("FAIL reset_no_div_clear: got %0d want 0", dc_cnt[0] - dc0);
    end
  endtask

  task automatic test_mode_tick_same_cycle();
    // Press pulse is registered 6 edges after the key goes low.
    key_mode_n[0] = 1'b0;
    step(6);
    tick[0] = 1'b1;
    step(1);
    tick[0] = 1'b0;
    vectors++;
    if (mode[0] !== 2'b01 || hms(0) !== 24'h000001) begin
      miscompares++;
      $display("FAIL mode_tick_same: got mode=%b time=%h want 01 000001", mode[0], hms(0));
    end
    step(3);
    key_mode_n[0] = 1'b1;
    step(10);
    press(0, 1'b0);
    press(0, 1'b0);
    vectors++;
    if (mode[0] !== 2'b00 || hms(0) !== 24'h000000) begin
      miscompares++;
      $display("FAIL mode_tick_exit: got mode=%b time=%h want 00 000000", mode[0], hms(0));
    end
  endtask

  task automatic test_12h();
    set_time(1, 11, 59);
    vectors++;
    if (hms(1) !== 24'h115900 || pm[1] !== 1'b0) begin
      miscompares++; $display("FAIL h12_preload_1159: got %h pm=%b want 115900 pm=0", hms(1), pm[1]);
    end
    ticks(1, 59);
    tick[1] = 1'b1;
    step(1);
    tick[1] = 1'b0;
    vectors++;
    if (hms(1) !== 24'h120000 || pm[1] !== 1'b1) begin
      miscompares++; $display("FAIL h12_noon: got %h pm=%b want 120000 pm=1", hms(1), pm[1]);
    end
    step(1);
    set_time(1, 0, 59);
    ticks(1, 59);
    vectors++;
    if (hms(1) !== 24'h125959 || pm[1] !== 1'b1) begin
      miscompares++; $display("FAIL h12_preload_125959: got %h pm=%b want 125959 pm=1", hms(1), pm[1]);
    end
    tick[1] = 1'b1;
    step(1);
    tick[1] = 1'b0;
    vectors++;
    if (hms(1) !== 24'h010000 || pm[1] !== 1'b1) begin
      miscompares++; $display("FAIL h12_one_pm: got %h pm=%b want 010000 pm=1", hms(1), pm[1]);
    end
  endtask

  initial begin
    test_reset();
    test_run_tick();
    test_set_sequence();
    test_rollover_24();
    test_debounce();
    test_mode_inc_same_cycle();
    test_reset_mid_edit();
    test_mode_tick_same_cycle();
    test_12h();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
